// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: completion result (sal_t), ROB flush window (flush_t)
// and the flush-window membership test used by the arbiter.
package cdb_arbiter_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic                 rdy;
        logic [DATA_W-1:0]    data;
    } sal_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] flush_tag;
        logic [ROB_TAG_W-1:0] front_tag;
        logic [ROB_TAG_W-1:0] rear_tag;
    } flush_t;

    // Distances are measured from flush_tag so a window that wraps past the
    // end of the ROB needs no special case.
    function automatic logic rob_in_flush_window(input logic [ROB_TAG_W-1:0] tag,
                                                 input flush_t               flush,
                                                 input int unsigned          rob_size);
        logic [ROB_TAG_W-1:0] tag_off;
        logic [ROB_TAG_W-1:0] rear_off;
        tag_off  = tag - flush.flush_tag;
        rear_off = flush.rear_tag - flush.flush_tag;
        return ((32'(tag_off) % rob_size) <= (32'(rear_off) % rob_size));
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible index starting at rr_ptr_i,
// wrapping at N. Grant is one-hot; grant_valid_o flags any eligible request.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             grant_valid_o
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible one wins.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(rr_ptr_i) + k) % N);
            if (eligible_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
            end
        end
        grant_valid_o = |eligible_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: kills results inside an active flush window, round-robin grants
// one surviving result per cycle and registers it onto the common data bus.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ROB_SIZE = 8,
    parameter int TAG_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  sal_t               req_i [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ack_o,
    input  flush_t             flush_i,
    output sal_t               cdb_o,
    output logic [CNT_W-1:0]   kill_cnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PC_W  = $clog2(NUM_REQ + 1);
    localparam int SUM_W = CNT_W + PC_W;

    logic [NUM_REQ-1:0] killed;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_idx;
    logic [TAG_W-1:0]   win_tag;
    sal_t               cdb_q, cdb_d;
    logic [CNT_W-1:0]   kill_cnt_q, kill_cnt_d;
    logic [PC_W-1:0]    kill_num;
    logic [SUM_W-1:0]   kill_sum;
    logic               unused_front;

    // The ROB only needs flush_tag/rear_tag for the window test here.
    assign unused_front = ^flush_i.front_tag;

    // A kill removes the request from arbitration in the same cycle.
    always_comb begin
        killed   = '0;
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            killed[i]   = flush_i.valid & req_i[i].rdy &
                          rob_in_flush_window(req_i[i].tag, flush_i, unsigned'(ROB_SIZE));
            eligible[i] = req_i[i].rdy & ~killed[i];
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .eligible_i    (eligible),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        win_idx = '0;
        win_tag = '0;
        cdb_d   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx    = PTR_W'(i);
                win_tag    = req_i[i].tag;
                cdb_d.data = req_i[i].data;
            end
        end
        if (grant_valid) begin
            cdb_d.tag = win_tag;
            cdb_d.rdy = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Summing in a wider word makes saturation a single compare.
    always_comb begin
        kill_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            kill_num = kill_num + PC_W'(killed[i]);
        end
        kill_sum   = SUM_W'(kill_cnt_q) + SUM_W'(kill_num);
        kill_cnt_d = (kill_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : kill_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            cdb_q      <= '0;
            kill_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cdb_q      <= cdb_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign req_ack_o  = rst ? '0 : (killed | grant);
    assign cdb_o      = cdb_q;
    assign kill_cnt_o = kill_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the kill/round-robin rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int RS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    sal_t          req [NR];
    flush_t        flush;
    logic [NR-1:0] ack, ack_sat;
    sal_t          cdb, cdb_sat;
    logic [15:0]   kcnt;
    logic [1:0]    kcnt_sat;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(NR), .ROB_SIZE(RS), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_ack_o(ack),
        .flush_i(flush), .cdb_o(cdb), .kill_cnt_o(kcnt)
    );

    cdb_arbiter #(.NUM_REQ(NR), .ROB_SIZE(RS), .TAG_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_i(req), .req_ack_o(ack_sat),
        .flush_i(flush), .cdb_o(cdb_sat), .kill_cnt_o(kcnt_sat)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int            m_rr, m_kill, m_kill_sat, m_win, m_nkill;
    sal_t          m_cdb;
    logic [NR-1:0] m_ack;

    function automatic int ring_dist(input int a, input int b);
        return (a - b + RS) % RS;
    endfunction

    task automatic eval();
        m_ack   = '0;
        m_win   = -1;
        m_nkill = 0;
        for (int i = 0; i < NR; i++) begin
            if (flush.valid && req[i].rdy &&
                ring_dist(int'(req[i].tag), int'(flush.flush_tag)) <=
                ring_dist(int'(flush.rear_tag), int'(flush.flush_tag))) begin
                m_ack[i] = 1'b1;
                m_nkill++;
            end
        end
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_rr + k) % NR;
            if (m_win < 0 && req[idx].rdy && !m_ack[idx]) m_win = idx;
        end
        if (m_win >= 0) m_ack[m_win] = 1'b1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_win >= 0) begin
            m_cdb = '{tag: req[m_win].tag, rdy: 1'b1, data: req[m_win].data};
            m_rr  = (m_win + 1) % NR;
        end else begin
            m_cdb = '0;
        end
        m_kill     = (m_kill + m_nkill > 65535) ? 65535 : m_kill + m_nkill;
        m_kill_sat = (m_kill_sat + m_nkill > 3) ? 3 : m_kill_sat + m_nkill;
        #1;
    endtask

    task automatic retire();
        for (int i = 0; i < NR; i++) if (m_ack[i]) req[i].rdy = 1'b0;
    endtask

    task automatic model_reset();
        m_rr = 0; m_kill = 0; m_kill_sat = 0; m_cdb = '0; m_ack = '0; m_win = -1; m_nkill = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) req[i] = '0;
        flush = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        req[0] = '{tag: 4'd3, rdy: 1'b1, data: $urandom};
        #1; eval();
        n_checks++;
        if ({ack, ack_sat} !== {m_ack, m_ack}) $display("FAIL reset pre ack: got %b want %b", ack, m_ack);
        else n_pass++;
        advance();
        n_checks++;
        if ({cdb, cdb_sat} !== {m_cdb, m_cdb}) $display("FAIL reset pre cdb: got %h want %h", cdb, m_cdb);
        else n_pass++;
        retire();
        req[0] = '{tag: 4'd5, rdy: 1'b1, data: $urandom};
        #1; rst = 1'b1; #1;
        n_checks++;
        if ({ack, ack_sat} !== '0) $display("FAIL reset ack_in_reset: got %b want 0000", ack);
        else n_pass++;
        n_checks++;
        if ({cdb, cdb_sat, kcnt, kcnt_sat} !== '0) $display("FAIL reset outputs: cdb %h kill %0d want 0", cdb, kcnt);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (cdb !== '0) $display("FAIL reset cdb_held: got %h want 0", cdb);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1; eval();
        n_checks++;
        if ({ack, ack_sat} !== {m_ack, m_ack} || ack !== 4'b0001) $display("FAIL reset post ack: got %b want 0001", ack);
        else n_pass++;
        advance();
        n_checks++;
        if (cdb !== m_cdb || cdb.tag !== 4'd5 || cdb.rdy !== 1'b1) $display("FAIL reset post cdb: got %h want %h", cdb, m_cdb);
        else n_pass++;
        retire();
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < NR; i++) req[i] = '{tag: 4'(i + 1), rdy: 1'b1, data: $urandom};
        for (int c = 0; c < NR; c++) begin
            #1; eval();
            n_checks++;
            if ({ack, ack_sat} !== {m_ack, m_ack}) $display("FAIL contention ack: got %b want %b", ack, m_ack);
            else n_pass++;
            advance();
            n_checks++;
            if (cdb !== m_cdb || cdb.tag !== 4'(c + 1)) $display("FAIL contention cdb: got %h want %h", cdb, m_cdb);
            else n_pass++;
            retire();
        end
        // Pointer should be back at 0: req 0 beats req 3.
        req[0] = '{tag: 4'd5, rdy: 1'b1, data: $urandom};
        req[3] = '{tag: 4'd6, rdy: 1'b1, data: $urandom};
        #1; eval();
        advance();
        n_checks++;
        if (cdb !== m_cdb || cdb.tag !== 4'd5) $display("FAIL contention rr_wrap: got %h want tag 5", cdb);
        else n_pass++;
        retire();
        #1; eval(); advance(); retire();
    endtask

    task automatic test_round_robin();
        apply_reset();
        req[1] = '{tag: 4'd6, rdy: 1'b1, data: $urandom};
        #1; eval(); advance(); retire();
        req[0] = '{tag: 4'd1, rdy: 1'b1, data: $urandom};
        req[3] = '{tag: 4'd2, rdy: 1'b1, data: $urandom};
        for (int c = 0; c < 2; c++) begin
            #1; eval();
            n_checks++;
            if ({ack, ack_sat} !== {m_ack, m_ack}) $display("FAIL round_robin ack: got %b want %b", ack, m_ack);
            else n_pass++;
            advance();
            n_checks++;
            if (cdb !== m_cdb || cdb.tag !== ((c == 0) ? 4'd2 : 4'd1)) $display("FAIL round_robin cdb: got %h want %h", cdb, m_cdb);
            else n_pass++;
            retire();
        end
    endtask

    task automatic test_flush(input int ft, input int rear, input int t0, input int t1, input int t2,
                              input int exp_kills, input int exp_tag);
        apply_reset();
        flush  = '{valid: 1'b1, flush_tag: 4'(ft), front_tag: 4'(ft), rear_tag: 4'(rear)};
        req[0] = '{tag: 4'(t0), rdy: 1'b1, data: $urandom};
        req[1] = '{tag: 4'(t1), rdy: 1'b1, data: $urandom};
        req[2] = '{tag: 4'(t2), rdy: (t2 >= 0), data: $urandom};
        #1; eval();
        n_checks++;
        if ({ack, ack_sat} !== {m_ack, m_ack} || $countones(ack) != exp_kills + 1)
            $display("FAIL flush ack: got %b want %b", ack, m_ack);
        else n_pass++;
        advance();
        retire();
        flush = '0;
        n_checks++;
        if (cdb !== m_cdb || cdb.tag !== 4'(exp_tag)) $display("FAIL flush cdb: got %h want %h", cdb, m_cdb);
        else n_pass++;
        n_checks++;
        if (kcnt !== 16'(m_kill) || kcnt !== 16'(exp_kills)) $display("FAIL flush kill_cnt: got %0d want %0d", kcnt, exp_kills);
        else n_pass++;
        #1; eval(); advance();
        n_checks++;
        if (cdb !== '0) $display("FAIL flush idle_cdb: got %h want 0", cdb);
        else n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        flush = '{valid: 1'b1, flush_tag: 4'd0, front_tag: 4'd0, rear_tag: 4'd7};
        for (int i = 0; i < NR; i++) req[i] = '{tag: 4'($urandom_range(0, 7)), rdy: 1'b1, data: $urandom};
        #1; eval(); advance(); retire();
        req[2] = '{tag: 4'd3, rdy: 1'b1, data: $urandom};
        #1; eval();
        n_checks++;
        if ({ack, ack_sat} !== {m_ack, m_ack}) $display("FAIL saturation ack: got %b want %b", ack, m_ack);
        else n_pass++;
        advance(); retire();
        flush = '0;
        n_checks++;
        if (kcnt_sat !== 2'd3 || kcnt !== 16'd5 || 2'(m_kill_sat) !== kcnt_sat)
            $display("FAIL saturation kill_cnt: got %0d/%0d want 3/5", kcnt_sat, kcnt);
        else n_pass++;
        n_checks++;
        if (cdb !== '0) $display("FAIL saturation cdb: got %h want 0", cdb);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++)
                if (!req[i].rdy && $urandom_range(0, 1) == 1)
                    req[i] = '{tag: 4'($urandom_range(0, 7)), rdy: 1'b1, data: $urandom};
            flush = '{valid: ($urandom_range(0, 3) == 0), flush_tag: 4'($urandom_range(0, 7)),
                      front_tag: 4'($urandom_range(0, 7)), rear_tag: 4'($urandom_range(0, 7))};
            #1; eval();
            n_checks++;
            if ({ack, ack_sat} !== {m_ack, m_ack}) $display("FAIL random ack c%0d: got %b want %b", c, ack, m_ack);
            else n_pass++;
            advance();
            n_checks++;
            if ({cdb, cdb_sat} !== {m_cdb, m_cdb}) $display("FAIL random cdb c%0d: got %h want %h", c, cdb, m_cdb);
            else n_pass++;
            n_checks++;
            if (kcnt !== 16'(m_kill) || kcnt_sat !== 2'(m_kill_sat))
                $display("FAIL random kill_cnt c%0d: got %0d/%0d want %0d/%0d", c, kcnt, kcnt_sat, m_kill, m_kill_sat);
            else n_pass++;
            retire();
        end
        flush = '0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) req[i] = '0;
        flush = '0;
        model_reset();
        test_reset();
        test_contention();
        test_round_robin();
        test_flush(3, 5, 2, 4, -1, 1, 2);
        test_flush(6, 1, 7, 0, 2, 2, 2);
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
